// File: rtl/clint_mem_responder.sv
// Core Local Interruptor bus responder: owns msip, ssip, mtime and mtimecmp,
// answers loads/stores with a one-cycle ack and exports the registers to the core.
module clint_mem_responder #(
  parameter int          DATA_SIZE      = 32,
  parameter int          CLOCK_CYCLES   = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [4:0]             addr,
  input  logic [DATA_SIZE/8-1:0] wr_strobe,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   ack,
  output logic [DATA_SIZE-1:0]   mem_msip,
  output logic [DATA_SIZE-1:0]   mem_ssip,
  output logic [63:0]            mem_mtime,
  output logic [63:0]            mem_mtimecmp
);

  localparam int STRB     = DATA_SIZE / 8;
  localparam int SLOT_LSB = (DATA_SIZE == 64) ? 3 : 2;
  localparam int PW       = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t               state, state_next;
  logic                 msip, ssip;
  logic [63:0]          mtime, mtimecmp;
  logic [PW-1:0]        prescaler;
  logic [2:0]           slot;
  logic                 sel_hi, sel_mtime, sel_mtimecmp;
  logic [5:0]           shamt;
  logic [DATA_SIZE-1:0] byte_mask, rd_mux;
  logic [63:0]          wmask, wdata;
  logic                 req, do_write, tick;

  assign slot = 3'(addr >> SLOT_LSB);

  // The 32-bit map splits each 64-bit timer register into lo/hi slots.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel_hi       = 1'b0;
    sel_mtime    = 1'b0;
    sel_mtimecmp = 1'b0;
    if (DATA_SIZE == 64) begin
      sel_mtime    = (slot == 3'd2);
      sel_mtimecmp = (slot == 3'd3);
    end else begin
      sel_mtime    = (slot[2:1] == 2'b01);
      sel_mtimecmp = (slot[2:1] == 2'b10);
      sel_hi       = slot[0];
    end
  end

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB; b++) byte_mask[b*8 +: 8] = {8{wr_strobe[b]}};
  end

  assign shamt = sel_hi ? 6'd32 : 6'd0;
  assign wmask = 64'(byte_mask) << shamt;
  assign wdata = 64'(wr_data) << shamt;

  always_comb begin
    rd_mux = '0;
    case (slot)
      3'd0:    rd_mux = DATA_SIZE'(msip);
      3'd1:    rd_mux = DATA_SIZE'(ssip);
      default: begin
        if (sel_mtime)         rd_mux = DATA_SIZE'(mtime >> shamt);
        else if (sel_mtimecmp) rd_mux = DATA_SIZE'(mtimecmp >> shamt);
      end
    endcase
  end

  assign req      = (state == IDLE) && (rd_en || wr_en);
  assign do_write = req && wr_en;
  assign tick     = (prescaler == PRESCALE_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_en || wr_en) state_next = ACK;
      ACK:     state_next = WAIT;
      WAIT:    if (!rd_en && !wr_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack = (state == ACK);
  end

  // A software write to mtime wins over a tick in the same cycle; the prescaler keeps running.
  always_ff @(posedge clock) begin
    if (!reset) begin
      msip      <= 1'b0;
      ssip      <= 1'b0;
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RESET;
      prescaler <= '0;
      rd_data   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (do_write && sel_mtime)  mtime <= (mtime & ~wmask) | (wdata & wmask);
      else if (tick)              mtime <= mtime + 64'd1;
      if (do_write && sel_mtimecmp) mtimecmp <= (mtimecmp & ~wmask) | (wdata & wmask);
      if (do_write && slot == 3'd0 && wr_strobe[0]) msip <= wr_data[0];
      if (do_write && slot == 3'd1 && wr_strobe[0]) ssip <= wr_data[0];
      if (req)                rd_data <= rd_mux;
      else if (state == ACK)  rd_data <= '0;
    end
  end

  assign mem_msip     = DATA_SIZE'(msip);
  assign mem_ssip     = DATA_SIZE'(ssip);
  assign mem_mtime    = mtime;
  assign mem_mtimecmp = mtimecmp;

endmodule

// File: tb/tb_clint_mem_responder.sv
// Directed bench for clint_mem_responder: a 32-bit instance with one clock per tick
// carries the bus traffic, a second instance with four clocks per tick checks the prescaler.
module tb_clint_mem_responder;

  logic        clock;
  logic        reset;
  logic        rd_en, wr_en;
  logic [4:0]  addr;
  logic [3:0]  wr_strobe;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic [31:0] mem_msip, mem_ssip;
  logic [63:0] mem_mtime, mem_mtimecmp;

  logic [31:0] rd_data4, msip4, ssip4;
  logic        ack4;
  logic [63:0] mtime4, mtimecmp4;

  int checks = 0;
  int passes = 0;

  clint_mem_responder #(.DATA_SIZE(32), .CLOCK_CYCLES(1)) u_dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_strobe(wr_strobe), .wr_data(wr_data), .rd_data(rd_data), .ack(ack),
    .mem_msip(mem_msip), .mem_ssip(mem_ssip), .mem_mtime(mem_mtime),
    .mem_mtimecmp(mem_mtimecmp)
  );

  clint_mem_responder #(.DATA_SIZE(32), .CLOCK_CYCLES(4)) u_dut4 (
    .clock(clock), .reset(reset), .rd_en(1'b0), .wr_en(1'b0), .addr(5'd0),
    .wr_strobe(4'd0), .wr_data(32'd0), .rd_data(rd_data4), .ack(ack4),
    .mem_msip(msip4), .mem_ssip(ssip4), .mem_mtime(mtime4), .mem_mtimecmp(mtimecmp4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One complete bus transaction: drive after a falling edge, wait (bounded) for ack,
  // release the request and let the FSM return to IDLE.
  task automatic bus(input logic rd, input logic wr, input logic [4:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rdat, output int acks,
                     output logic [63:0] mt_pre, output logic [63:0] mt_ack);
    acks   = 0;
    rdat   = '0;
    mt_ack = '0;
    @(negedge clock);
    rd_en = rd; wr_en = wr; addr = a; wr_strobe = s; wr_data = d;
    mt_pre = mem_mtime;
    for (int i = 0; i < 8 && acks == 0; i++) begin
      @(negedge clock);
      if (ack) begin
        acks   = 1;
        rdat   = rd_data;
        mt_ack = mem_mtime;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clock);
    if (ack) acks++;
  endtask

  logic [31:0] rdat;
  int          acks;
  logic [63:0] mt_pre, mt_ack;

  initial begin
    reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; wr_strobe = '0; wr_data = '0;
    repeat (3) @(negedge clock);
    check("rst_ack",      64'(ack),     64'd0);
    check("rst_mtime",    mem_mtime,    64'd0);
    check("rst_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_msip",     64'(mem_msip), 64'd0);
    check("rst_rd_data",  64'(rd_data), 64'd0);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("presc4_3clk",  mtime4, 64'd0);
    @(negedge clock);
    check("presc4_4clk",  mtime4, 64'd1);
    check("mtime_4clk",   mem_mtime, 64'd4);
    repeat (4) @(negedge clock);
    check("presc4_8clk",  mtime4, 64'd2);
    repeat (2) @(negedge clock);
    check("mtime_10clk",  mem_mtime, 64'd10);

    bus(1'b0, 1'b1, 5'h00, 4'hF, 32'hFFFF_FFFF, rdat, acks, mt_pre, mt_ack);
    check("msip_wr_acks", 64'(acks), 64'd1);
    check("msip_wr_old",  64'(rdat), 64'd0);
    check("msip_set",     64'(mem_msip), 64'd1);
    bus(1'b1, 1'b0, 5'h00, 4'h0, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("msip_rd",      64'(rdat), 64'd1);
    bus(1'b0, 1'b1, 5'h00, 4'hE, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("msip_nostrb",  64'(mem_msip), 64'd1);

    // Held store: exactly one ack, rd_data cleared after ACK, FSM back to IDLE after release.
    @(negedge clock);
    wr_en = 1'b1; addr = 5'h04; wr_strobe = 4'h1; wr_data = 32'h1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack) acks++;
    end
    check("hold_rd_data0", 64'(rd_data), 64'd0);
    wr_en = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (ack) acks++;
    end
    check("hold_acks",     64'(acks), 64'd1);
    check("ssip_set",      64'(mem_ssip), 64'd1);
    bus(1'b1, 1'b0, 5'h04, 4'h0, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("ssip_rd_acks",  64'(acks), 64'd1);
    check("ssip_rd",       64'(rdat), 64'd1);

    // mtime low half rollover carries through the tick, not through the write.
    bus(1'b0, 1'b1, 5'h08, 4'hF, 32'hFFFF_FFFF, rdat, acks, mt_pre, mt_ack);
    check("mtime_lo_wr",   mt_ack,    64'h0000_0000_FFFF_FFFF);
    check("mtime_carry",   mem_mtime, 64'h0000_0001_0000_0000);
    bus(1'b0, 1'b1, 5'h0C, 4'hF, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("mtime_pre_hi",  mt_pre,    64'h0000_0001_0000_0001);
    check("mtime_hi_old",  64'(rdat), 64'd1);
    check("mtime_hi_wr",   mt_ack,    64'h0000_0000_0000_0001);
    check("mtime_resume",  mem_mtime, 64'h0000_0000_0000_0002);

    bus(1'b0, 1'b1, 5'h10, 4'b0011, 32'h1234_5678, rdat, acks, mt_pre, mt_ack);
    check("cmp_lo_old",    64'(rdat), 64'h0000_0000_FFFF_FFFF);
    check("cmp_lo_strb",   mem_mtimecmp, 64'hFFFF_FFFF_FFFF_5678);
    bus(1'b0, 1'b1, 5'h18, 4'hF, 32'hDEAD_BEEF, rdat, acks, mt_pre, mt_ack);
    check("rsvd_wr_acks",  64'(acks), 64'd1);
    check("rsvd_wr_old",   64'(rdat), 64'd0);
    bus(1'b1, 1'b0, 5'h1C, 4'h0, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("rsvd_rd",       64'(rdat), 64'd0);
    check("rsvd_no_side",  mem_mtimecmp, 64'hFFFF_FFFF_FFFF_5678);

    // Load+store together behaves as a store returning the old value; reset in ACK aborts.
    @(negedge clock);
    rd_en = 1'b1; wr_en = 1'b1; addr = 5'h14; wr_strobe = 4'hF; wr_data = 32'h0;
    @(negedge clock);
    check("rw_ack",        64'(ack), 64'd1);
    check("rw_old_hi",     64'(rd_data), 64'h0000_0000_FFFF_FFFF);
    check("rw_cmp_hi0",    mem_mtimecmp, 64'h0000_0000_FFFF_5678);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ack_drop",  64'(ack), 64'd0);
    check("rst_rd_clr",    64'(rd_data), 64'd0);
    check("rst_mtime2",    mem_mtime, 64'd0);
    check("rst_cmp2",      mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_msip2",     64'(mem_msip), 64'd0);
    check("rst_ssip2",     64'(mem_ssip), 64'd0);

    rd_en = 1'b0; wr_en = 1'b1; addr = 5'h00; wr_strobe = 4'h1; wr_data = 32'h1;
    @(negedge clock);
    check("rst_no_write",  64'(mem_msip), 64'd0);
    check("rst_no_ack",    64'(ack), 64'd0);
    wr_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle", 64'(ack), 64'd0);
    bus(1'b1, 1'b0, 5'h14, 4'h0, 32'h0, rdat, acks, mt_pre, mt_ack);
    check("post_rst_acks", 64'(acks), 64'd1);
    check("post_rst_cmp",  64'(rdat), 64'h0000_0000_FFFF_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
